// File: rtl/piso_serializer_if.sv
// Frame-in / word-out handshake bundle for piso_serializer.
// The serializer is the master of the serial stream; the frame source and sink use the slave view.
interface piso_serializer_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic [N*M-1:0] PI;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   SO;
    logic           so_valid;
    logic           so_ready;
    logic           so_last;

    modport master (
        input  PI, in_valid, so_ready,
        output in_ready, SO, so_valid, so_last
    );

    modport slave (
        output PI, in_valid, so_ready,
        input  in_ready, SO, so_valid, so_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out frame serializer: one M-word frame in, M words out (word 0 first),
// with a same-cycle reload on the last beat so back-to-back frames stream without gaps.
module piso_serializer #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic              Clk,
    input  logic              Clr,
    piso_serializer_if.master bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_next;
    logic [IW-1:0]  idx, idx_next;
    logic [N*M-1:0] frame, frame_next;
    logic           last, load, beat;
    logic [N-1:0]   word_sel;

    // Everything visible at the outputs is decoded from registered state only;
    // in_ready alone also looks at so_ready so a reload can overlap the last beat.
    assign last         = (state == SHIFT) && (idx == LAST_IDX);
    assign bus.in_ready = !Clr && ((state == IDLE) || (last && bus.so_ready));
    assign load         = bus.in_valid && bus.in_ready;
    assign beat         = (state == SHIFT) && bus.so_ready;

    always_comb word_sel = frame[int'(idx)*N +: N];

    assign bus.so_valid = (state == SHIFT);
    assign bus.so_last  = last;
    assign bus.SO       = (state == SHIFT) ? word_sel : '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_next = state;
        idx_next   = idx;
        frame_next = frame;
        case (state)
            IDLE: begin
                if (load) begin
                    frame_next = bus.PI;
                    idx_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (!last) begin
                        idx_next = idx + 1'b1;
                    end else if (load) begin
                        frame_next = bus.PI;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the frame register is cleared too, so a discarded frame can never leak onto SO later.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
        if (Clr) begin
            state <= IDLE;
            idx   <= '0;
            frame <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            frame <= frame_next;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4x4-bit instance for framing, backpressure, streaming
// and mid-frame clear, plus a 1x8-bit instance for single-word frames.
module tb_piso_serializer;
    logic Clk = 1'b0;
    logic Clr;

    always #5 Clk = ~Clk;

    piso_serializer_if #(.N(4), .M(4)) b4 ();
    piso_serializer_if #(.N(8), .M(1)) b1 ();

    piso_serializer #(.N(4), .M(4)) dut4 (.Clk(Clk), .Clr(Clr), .bus(b4));
    piso_serializer #(.N(8), .M(1)) dut1 (.Clk(Clk), .Clr(Clr), .bus(b1));

    int total = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs of the 4x4 instance.
    task automatic out4(input string tag, input logic v, input logic [3:0] so,
                        input logic l, input logic r);
        check({tag, ".so_valid"}, 16'(b4.so_valid), 16'(v));
        check({tag, ".SO"},       16'(b4.SO),       16'(so));
        check({tag, ".so_last"},  16'(b4.so_last),  16'(l));
        check({tag, ".in_ready"}, 16'(b4.in_ready), 16'(r));
    endtask

    task automatic out1(input string tag, input logic v, input logic [7:0] so,
                        input logic l, input logic r);
        check({tag, ".so_valid"}, 16'(b1.so_valid), 16'(v));
        check({tag, ".SO"},       16'(b1.SO),       16'(so));
        check({tag, ".so_last"},  16'(b1.so_last),  16'(l));
        check({tag, ".in_ready"}, 16'(b1.in_ready), 16'(r));
    endtask

    // Inputs change 1 time unit after a rising edge; checks run 1 unit later.
    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        Clr = 1'b1;
        b4.PI = '0; b4.in_valid = 1'b0; b4.so_ready = 1'b1;
        b1.PI = '0; b1.in_valid = 1'b0; b1.so_ready = 1'b1;
        next(); next(); settle();
        out4("rst4", 1'b0, 4'h0, 1'b0, 1'b0);
        out1("rst1", 1'b0, 8'h00, 1'b0, 1'b0);
        Clr = 1'b0; settle();
        out4("rst4_rel", 1'b0, 4'h0, 1'b0, 1'b1);
        out1("rst1_rel", 1'b0, 8'h00, 1'b0, 1'b1);

        // Basic frame
        next();
        b4.PI = 16'hA5C3; b4.in_valid = 1'b1; settle();
        out4("basic_idle", 1'b0, 4'h0, 1'b0, 1'b1);
        next(); b4.in_valid = 1'b0; settle();
        out4("basic_w0", 1'b1, 4'h3, 1'b0, 1'b0);
        next(); settle(); out4("basic_w1", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); settle(); out4("basic_w2", 1'b1, 4'h5, 1'b0, 1'b0);
        next(); settle(); out4("basic_w3", 1'b1, 4'hA, 1'b1, 1'b1);
        next(); settle(); out4("basic_end", 1'b0, 4'h0, 1'b0, 1'b1);

        // Backpressure on word 1, with an in_valid pulse that must be ignored
        b4.PI = 16'hA5C3; b4.in_valid = 1'b1;
        next(); b4.in_valid = 1'b0; settle();
        out4("bp_w0", 1'b1, 4'h3, 1'b0, 1'b0);
        next(); b4.so_ready = 1'b0; settle();
        out4("bp_hold1", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); b4.PI = 16'hFFFF; b4.in_valid = 1'b1; settle();
        out4("bp_hold2", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); b4.in_valid = 1'b0; settle();
        out4("bp_hold3", 1'b1, 4'hC, 1'b0, 1'b0);
        b4.so_ready = 1'b1; settle();
        out4("bp_release", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); settle(); out4("bp_w2", 1'b1, 4'h5, 1'b0, 1'b0);
        next(); settle(); out4("bp_w3", 1'b1, 4'hA, 1'b1, 1'b1);
        next(); settle(); out4("bp_end", 1'b0, 4'h0, 1'b0, 1'b1);

        // Back-to-back frames with in_valid held high
        b4.PI = 16'h1234; b4.in_valid = 1'b1; settle();
        out4("b2b_idle", 1'b0, 4'h0, 1'b0, 1'b1);
        next(); b4.PI = 16'hFEDC; settle();
        out4("b2b_a0", 1'b1, 4'h4, 1'b0, 1'b0);
        next(); settle(); out4("b2b_a1", 1'b1, 4'h3, 1'b0, 1'b0);
        next(); settle(); out4("b2b_a2", 1'b1, 4'h2, 1'b0, 1'b0);
        next(); settle(); out4("b2b_a3", 1'b1, 4'h1, 1'b1, 1'b1);
        next(); b4.in_valid = 1'b0; settle();
        out4("b2b_b0", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); settle(); out4("b2b_b1", 1'b1, 4'hD, 1'b0, 1'b0);
        next(); settle(); out4("b2b_b2", 1'b1, 4'hE, 1'b0, 1'b0);
        next(); settle(); out4("b2b_b3", 1'b1, 4'hF, 1'b1, 1'b1);
        next(); settle(); out4("b2b_end", 1'b0, 4'h0, 1'b0, 1'b1);

        // Clear while word 2 is presented
        b4.PI = 16'hA5C3; b4.in_valid = 1'b1;
        next(); b4.in_valid = 1'b0; settle();
        out4("clr_w0", 1'b1, 4'h3, 1'b0, 1'b0);
        next(); settle(); out4("clr_w1", 1'b1, 4'hC, 1'b0, 1'b0);
        next(); Clr = 1'b1; settle();
        out4("clr_w2", 1'b1, 4'h5, 1'b0, 1'b0);
        next(); settle(); out4("clr_after", 1'b0, 4'h0, 1'b0, 1'b0);
        Clr = 1'b0; settle();
        out4("clr_rel", 1'b0, 4'h0, 1'b0, 1'b1);
        next(); settle(); out4("clr_quiet", 1'b0, 4'h0, 1'b0, 1'b1);
        b4.PI = 16'h9876; b4.in_valid = 1'b1;
        next(); b4.in_valid = 1'b0; settle();
        out4("clr_new_w0", 1'b1, 4'h6, 1'b0, 1'b0);
        next(); settle(); out4("clr_new_w1", 1'b1, 4'h7, 1'b0, 1'b0);
        next(); settle(); out4("clr_new_w2", 1'b1, 4'h8, 1'b0, 1'b0);
        next(); settle(); out4("clr_new_w3", 1'b1, 4'h9, 1'b1, 1'b1);
        next(); settle(); out4("clr_new_end", 1'b0, 4'h0, 1'b0, 1'b1);

        // Single-word frames, continuous loads
        b1.PI = 8'h11; b1.in_valid = 1'b1; settle();
        out1("m1_idle", 1'b0, 8'h00, 1'b0, 1'b1);
        next(); b1.PI = 8'h22; settle();
        out1("m1_w11", 1'b1, 8'h11, 1'b1, 1'b1);
        next(); b1.PI = 8'h33; settle();
        out1("m1_w22", 1'b1, 8'h22, 1'b1, 1'b1);
        next(); b1.in_valid = 1'b0; settle();
        out1("m1_w33", 1'b1, 8'h33, 1'b1, 1'b1);
        next(); settle(); out1("m1_end", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
